// File: rtl/uart_pkg.sv
// Shared UART constants: sequencer state encoding, default FIFO geometry and baud timing.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;

  localparam int DEF_DEPTH    = 16;
  localparam int DEF_DW       = 8;
  localparam int CLK_HZ       = 100_000_000;
  localparam int BAUD         = 9600;
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered occupancy count; full/empty decode from the count register.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DW-1:0]          push_data,
  input  logic                   pop,
  output logic [DW-1:0]          head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  // A push against a full FIFO is dropped even if a pop frees a slot this cycle.
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers pushed bytes and feeds them one frame at a time to a UART transmitter.
// Optional sticky overflow flag enabled by defining UART_TX_FEEDER_OVF_EN.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int DW    = DEF_DW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DW-1:0]          push_data,
  input  logic                   tx_busy,
  output logic                   tx_start,
  output logic [DW-1:0]          tx_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ovf
);

  tx_state_e     state;
  tx_state_e     state_nxt;
  logic          pop;
  logic [DW-1:0] head;

  sync_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      state    <= state_nxt;
      tx_start <= (state_nxt == LOAD);
      if (pop) tx_data <= head;
    end
  end

  // Wait for busy to rise and then fall so a new byte is only issued after the frame completes.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !tx_busy) begin
          pop       = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD:      state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy) state_nxt = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

`ifdef UART_TX_FEEDER_OVF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf <= 1'b0;
    else if (push && full) ovf <= 1'b1;
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scenario bench for uart_tx_feeder with a small UART TX busy model and an in-order byte scoreboard.
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;
  localparam int DW    = 8;
  localparam int FRAME = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic          push;
  logic [DW-1:0] push_data;
  logic          tx_busy;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic          full;
  logic          empty;
  logic [4:0]    count;
  logic          ovf;

  logic          stall;
  logic          busy_m;
  int            frame_cnt;

  int            total = 0;
  int            bad = 0;
  int            viol = 0;
  int            start_cnt = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_b;
  logic          prev_start = 1'b0;
  logic          prev_busy = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          exp_ovf;

  uart_tx_feeder #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // UART TX model: registers start, stays busy for FRAME cycles.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_m    <= 1'b0;
      frame_cnt <= 0;
    end else if (frame_cnt != 0) begin
      frame_cnt <= frame_cnt - 1;
      if (frame_cnt == 1) busy_m <= 1'b0;
    end else if (tx_start && !tx_busy) begin
      busy_m    <= 1'b1;
      frame_cnt <= FRAME;
    end
  end

  assign tx_busy = busy_m | stall;

  // Scoreboard consumer and protocol watch.
  always @(negedge clk) begin
    if (rst) begin
      if (tx_start) begin
        start_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_start: tx_data=%h with no byte expected", tx_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (tx_data !== exp_b) begin
            bad++;
            $display("FAIL tx_byte: got %h expected %h", tx_data, exp_b);
          end
        end
        if (tx_busy || prev_start) viol++;
      end
      if (tx_busy && prev_busy && tx_data !== prev_data) viol++;
    end
    prev_start = tx_start;
    prev_busy  = tx_busy;
    prev_data  = tx_data;
  end

  task automatic do_push(input logic [DW-1:0] d, input bit accept);
    push      = 1'b1;
    push_data = d;
    if (accept) exp_q.push_back(d);
    @(negedge clk);
    push      = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int stable = 0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !tx_busy && empty && !tx_start) stable++;
      else stable = 0;
      if (stable >= 3) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; push = 1'b0; push_data = '0; stall = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (empty !== 1'b1)   begin bad++; $display("FAIL reset_empty: got %b expected 1", empty); end
    total++; if (full !== 1'b0)    begin bad++; $display("FAIL reset_full: got %b expected 0", full); end
    total++; if (count !== 5'd0)   begin bad++; $display("FAIL reset_count: got %0d expected 0", count); end
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    total++; if (ovf !== 1'b0)     begin bad++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
  endtask

  task automatic test_single();
    bit ok;
    do_push(8'hA5, 1'b1);
    total++; if (count !== 5'd1)    begin bad++; $display("FAIL single_count1: got %0d expected 1", count); end
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL single_early_start: got %b expected 0", tx_start); end
    @(negedge clk);
    total++; if (tx_start !== 1'b1) begin bad++; $display("FAIL single_start: got %b expected 1", tx_start); end
    total++; if (count !== 5'd0)    begin bad++; $display("FAIL single_count0: got %0d expected 0", count); end
    @(negedge clk);
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL single_pulse_width: got %b expected 0", tx_start); end
    total++; if (tx_busy !== 1'b1)  begin bad++; $display("FAIL single_busy_rise: got %b expected 1", tx_busy); end
    wait_idle(500, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_timeout: got busy/pending expected idle"); end
    total++; if (tx_data !== 8'hA5) begin bad++; $display("FAIL single_hold: got %h expected a5", tx_data); end
  endtask

  task automatic test_burst();
    bit ok;
    int s0 = start_cnt;
    for (int i = 1; i <= 5; i++) do_push(8'(i), 1'b1);
    wait_idle(2000, ok);
    total++; if (!ok) begin bad++; $display("FAIL burst_timeout: got pending=%0d expected 0", exp_q.size()); end
    total++; if (start_cnt - s0 != 5) begin bad++; $display("FAIL burst_starts: got %0d expected 5", start_cnt - s0); end
    total++; if (viol != 0) begin bad++; $display("FAIL burst_protocol: got %0d violations expected 0", viol); end
  endtask

  task automatic test_full_ovf();
    bit ok;
    stall = 1'b1;
    @(negedge clk);
    for (int i = 0; i <= DEPTH; i++) do_push(8'h40 + 8'(i), i < DEPTH);
`ifdef UART_TX_FEEDER_OVF_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    total++; if (full !== 1'b1)        begin bad++; $display("FAIL full_flag: got %b expected 1", full); end
    total++; if (count !== 5'(DEPTH))  begin bad++; $display("FAIL full_count: got %0d expected %0d", count, DEPTH); end
    total++; if (ovf !== exp_ovf)      begin bad++; $display("FAIL ovf_flag: got %b expected %b", ovf, exp_ovf); end
    total++; if (tx_start !== 1'b0)    begin bad++; $display("FAIL stall_start: got %b expected 0", tx_start); end
    stall = 1'b0;
    wait_idle(3000, ok);
    total++; if (!ok) begin bad++; $display("FAIL full_drain_timeout: got pending=%0d expected 0", exp_q.size()); end
    total++; if (viol != 0) begin bad++; $display("FAIL full_protocol: got %0d violations expected 0", viol); end
  endtask

  task automatic test_wrap();
    bit ok;
    int s0 = start_cnt;
    for (int b = 0; b < 3 * DEPTH / 6; b++) begin
      for (int i = 0; i < 6; i++) do_push(8'((b * 6 + i) * 7 + 3), 1'b1);
      repeat (250) @(negedge clk);
    end
    wait_idle(4000, ok);
    total++; if (!ok) begin bad++; $display("FAIL wrap_timeout: got pending=%0d expected 0", exp_q.size()); end
    total++; if (start_cnt - s0 != 3 * DEPTH) begin bad++; $display("FAIL wrap_starts: got %0d expected %0d", start_cnt - s0, 3 * DEPTH); end
    total++; if (viol != 0) begin bad++; $display("FAIL wrap_protocol: got %0d violations expected 0", viol); end
  endtask

  task automatic test_mid_reset();
    bit ok;
    int s0;
    for (int i = 0; i < 5; i++) do_push(8'hC0 + 8'(i), 1'b1);
    repeat (10) @(negedge clk);
    total++; if (count !== 5'd4)   begin bad++; $display("FAIL mid_count: got %0d expected 4", count); end
    total++; if (tx_busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b expected 1", tx_busy); end
    rst = 1'b0;
    exp_q.delete();
    #1;
    total++; if (count !== 5'd0)    begin bad++; $display("FAIL mid_rst_count: got %0d expected 0", count); end
    total++; if (empty !== 1'b1)    begin bad++; $display("FAIL mid_rst_empty: got %b expected 1", empty); end
    total++; if (full !== 1'b0)     begin bad++; $display("FAIL mid_rst_full: got %b expected 0", full); end
    total++; if (tx_start !== 1'b0) begin bad++; $display("FAIL mid_rst_start: got %b expected 0", tx_start); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL mid_rst_data: got %h expected 00", tx_data); end
    total++; if (ovf !== 1'b0)      begin bad++; $display("FAIL mid_rst_ovf: got %b expected 0", ovf); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    s0 = start_cnt;
    repeat (100) @(negedge clk);
    total++; if (start_cnt != s0) begin bad++; $display("FAIL mid_no_start: got %0d starts expected 0", start_cnt - s0); end
    do_push(8'h3C, 1'b1);
    wait_idle(500, ok);
    total++; if (!ok) begin bad++; $display("FAIL mid_after_timeout: got pending=%0d expected 0", exp_q.size()); end
    total++; if (start_cnt - s0 != 1) begin bad++; $display("FAIL mid_after_starts: got %0d expected 1", start_cnt - s0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_full_ovf();
    test_wrap();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
